ring_link_arbiter: RTL and testbench
====================================

// Module: ring_link_arbiter
// PURPOSE
//  Packet-atomic (wormhole) arbiter sharing one ring router output link between two flit sources:
//  ring-through traffic from the upstream input buffer and local injection from the serializer shim.
//  Issues flits on the credit-based send/credit link. Tracks downstream buffer credits.
//  Bounds local-injection starvation with a ring burst limit. Sits between the router input buffers and the ring link.
// PARAMETERS
//  FLIT_WIDTH        128  flit payload width
//  DEST_WIDTH        6    destination field width ({tid, tdest})
//  FLIT_BUFFER_DEPTH 4    downstream buffer depth = initial credit count (>=1)
//  RING_BURST_LIMIT  2    max consecutive ring packets granted while local waits (>=1; 1 = round-robin)
// PORTS
//  clk           in   1           NoC clock
//  rst           in   1           async active-high reset
//  ring_valid    in   1           ring-through head flit valid
//  ring_ready    out  1           ring-through flit accepted when valid&ready
//  ring_data     in   FLIT_WIDTH  ring-through flit payload
//  ring_dest     in   DEST_WIDTH  ring-through flit destination
//  ring_is_tail  in   1           ring-through flit is packet tail
//  local_valid   in   1           local head flit valid
//  local_ready   out  1           local flit accepted when valid&ready
//  local_data    in   FLIT_WIDTH  local flit payload
//  local_dest    in   DEST_WIDTH  local flit destination
//  local_is_tail in   1           local flit is packet tail
//  data_out      out  FLIT_WIDTH  link flit payload (registered)
//  dest_out      out  DEST_WIDTH  link flit destination (registered)
//  is_tail_out   out  1           link tail marker (registered)
//  send_out      out  1           link flit valid, 1-cycle pulse per flit (registered)
//  credit_in     in   1           one downstream buffer slot freed
//  credit_err    out  1           sticky: credit_in received while counter full
// BEHAVIOUR
//  Reset (async): send_out/data_out/dest_out/is_tail_out/credit_err=0; credits=FLIT_BUFFER_DEPTH;
//    FSM=IDLE; burst counter=0. Readies go low immediately. Reset mid-packet drops the packet;
//    upstream/downstream reset together.
//  Credit counter width $clog2(FLIT_BUFFER_DEPTH+1). Flit may issue only if credits>0, using the value
//    registered at cycle start (credit_in of this cycle usable next cycle). Accept: -1; credit_in: +1;
//    both: unchanged. credit_in at full: counter saturates, credit_err set until reset.
//  Handshake: ready is combinational from FSM, credits and valids; valid must not depend on ready.
//    Flit accepted in cycle t -> send_out=1 with that flit's data/dest/tail in cycle t+1.
//    No accept -> send_out=0, data regs hold. Throughput 1 flit/cycle while credits last.
//  FSM IDLE: pick winner among valid heads. Ring wins unless local_valid and burst==RING_BURST_LIMIT.
//    Local wins when it alone is valid. Winner ready=credits>0, loser ready=0.
//    On accept: tail -> stay IDLE; else -> LOCK_RING / LOCK_LOCAL. Credits=0 -> no grant, re-arbitrate next cycle.
//  FSM LOCK_x: only x ready (=credits>0); other ready=0. Accept of x tail -> IDLE.
//    Bubbles (x not valid) hold the lock.
//  Burst counter: updated on head acceptance. Ring head while local_valid -> +1 (saturate at limit).
//    Local head -> 0. Ring head with local idle -> 0.
//  Packets never interleave on the link: a tail always precedes the next head from a different source.
// TESTING
//  1 Reset, DEPTH=4: local 3-flit packet, no ring -> send_out high 3 consecutive cycles, tail on 3rd, credits=1.
//  2 Ring 6-flit packet, no credit_in -> exactly 4 flits sent, ring_ready=0. credit_in pulse at cycle k -> flit 5 send_out at k+2.
//  3 Both valid continuously, 2-flit packets, LIMIT=2, credits returned each cycle -> link packet order R,R,L,R,R,L.
//    No interleaving within packets.
//  4 Local valid mid ring packet (LOCK_RING, ring bubble 2 cycles) -> local_ready=0 until ring tail accepted.
//  5 credits=1, accept and credit_in same cycle -> credits stay 1. credit_in while credits=4 -> credit_err=1, credits=4.
//  6 Assert rst mid ring packet -> send_out=0, readies=0 immediately. After release: credits=4, IDLE.
//    New local head is granted first cycle.

Source files
------------

// File: rtl/ring_link_arbiter.sv
// ring_link_arbiter: packet-atomic arbiter of ring-through and local flits onto one credit-based ring link
module ring_link_arbiter #(
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int RING_BURST_LIMIT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ring_valid,
  output logic                  ring_ready,
  input  logic [FLIT_WIDTH-1:0] ring_data,
  input  logic [DEST_WIDTH-1:0] ring_dest,
  input  logic                  ring_is_tail,
  input  logic                  local_valid,
  output logic                  local_ready,
  input  logic [FLIT_WIDTH-1:0] local_data,
  input  logic [DEST_WIDTH-1:0] local_dest,
  input  logic                  local_is_tail,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic                  credit_err
);
  localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int BW = $clog2(RING_BURST_LIMIT + 1);
  localparam logic [CW-1:0] FULL = CW'(FLIT_BUFFER_DEPTH);
  localparam logic [BW-1:0] LIM = BW'(RING_BURST_LIMIT);
  typedef enum logic [1:0] {IDLE, LOCK_RING, LOCK_LOCAL} state_t;
  state_t state;
  logic [CW-1:0] credits;
  logic [BW-1:0] burst;
  logic has_credit, ring_win, ring_acc, local_acc, acc, tail;
  // readies are masked during reset so a mid-packet reset stalls both sources at once
  always_comb begin
    has_credit = credits != '0;
    ring_win = ring_valid && !(local_valid && burst == LIM);
    ring_ready = !rst && has_credit && (state == IDLE ? ring_win : state == LOCK_RING);
    local_ready = !rst && has_credit && (state == IDLE ? local_valid && !ring_win : state == LOCK_LOCAL);
    ring_acc = ring_valid && ring_ready;
    local_acc = local_valid && local_ready;
    acc = ring_acc || local_acc;
    tail = ring_acc ? ring_is_tail : local_is_tail;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      credits <= FULL;
      burst <= '0;
      send_out <= 1'b0;
      data_out <= '0;
      dest_out <= '0;
      is_tail_out <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      send_out <= acc;
      if (acc) begin
        data_out <= ring_acc ? ring_data : local_data;
        dest_out <= ring_acc ? ring_dest : local_dest;
        is_tail_out <= tail;
        state <= tail ? IDLE : state == IDLE ? (ring_acc ? LOCK_RING : LOCK_LOCAL) : state;
      end
      if (acc && state == IDLE)
        burst <= ring_acc && local_valid ? (burst == LIM ? burst : burst + 1'b1) : '0;
      credits <= credit_in && credits == FULL ? credits : credits - CW'(acc) + CW'(credit_in);
      if (credit_in && credits == FULL) credit_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ring_link_arbiter.sv
// tb_ring_link_arbiter: directed and randomized checks of ring_link_arbiter against a packet-level model
module tb_ring_link_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 2;
  typedef struct {logic [127:0] d; logic [5:0] t; logic tl;} flit_t;
  logic clk = 0, rst = 1;
  logic ring_valid = 0, ring_is_tail = 0, local_valid = 0, local_is_tail = 0, credit_in = 0;
  logic [127:0] ring_data = '0, local_data = '0;
  logic [5:0] ring_dest = '0, local_dest = '0;
  logic ring_ready, local_ready, is_tail_out, send_out, credit_err;
  logic [127:0] data_out;
  logic [5:0] dest_out;
  int checks = 0, errors = 0, sends = 0, pkt_id = 0;
  flit_t ring_q[$], local_q[$];
  int m_cred, m_burst, m_owner;
  logic m_err, exp_send, exp_tail;
  logic [127:0] exp_data;
  logic [5:0] exp_dest;
  string order;
  bit in_pkt;
  logic [31:0] cur_src;

  ring_link_arbiter #(.FLIT_WIDTH(128), .DEST_WIDTH(6), .FLIT_BUFFER_DEPTH(DEPTH), .RING_BURST_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .ring_valid(ring_valid), .ring_ready(ring_ready), .ring_data(ring_data), .ring_dest(ring_dest), .ring_is_tail(ring_is_tail),
    .local_valid(local_valid), .local_ready(local_ready), .local_data(local_data), .local_dest(local_dest), .local_is_tail(local_is_tail),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .send_out(send_out),
    .credit_in(credit_in), .credit_err(credit_err));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic push(input int src, input int len);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f.d = {32'(src), 32'(pkt_id), 32'(i), 32'($urandom)};
      f.t = 6'($urandom);
      f.tl = (i == len - 1);
      if (src == 1) ring_q.push_back(f); else local_q.push_back(f);
    end
    pkt_id++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_send_out", send_out, 0);
    chk("rst_ring_ready", ring_ready, 0);
    chk("rst_local_ready", local_ready, 0);
    ring_q.delete();
    local_q.delete();
    ring_valid = 0;
    local_valid = 0;
    credit_in = 0;
    m_cred = DEPTH; m_burst = 0; m_owner = 0; m_err = 0;
    exp_send = 0; exp_tail = 0; exp_data = '0; exp_dest = '0;
    order = ""; in_pkt = 0; sends = 0;
    @(negedge clk);
    rst = 0;
  endtask

  // one link cycle: check registered outputs, drive sources, check readies, advance the model
  task automatic cyc(input bit rv_en, input bit lv_en, input bit ci);
    bit ok, rwin, er, el, acc_r, acc_l, tl;
    @(negedge clk);
    chk("send_out", send_out, exp_send);
    chk("data_out", data_out, exp_data);
    chk("dest_out", dest_out, exp_dest);
    chk("is_tail_out", is_tail_out, exp_tail);
    chk("credit_err", credit_err, m_err);
    if (send_out === 1'b1) begin
      sends++;
      if (!in_pkt) order = {order, data_out[127:96] == 1 ? "R" : "L"};
      else chk("no_interleave", data_out[127:96], cur_src);
      cur_src = data_out[127:96];
      in_pkt = !is_tail_out;
    end
    ring_valid = rv_en && ring_q.size() > 0;
    local_valid = lv_en && local_q.size() > 0;
    ring_data = ring_valid ? ring_q[0].d : '0;
    ring_dest = ring_valid ? ring_q[0].t : '0;
    ring_is_tail = ring_valid ? ring_q[0].tl : 1'b0;
    local_data = local_valid ? local_q[0].d : '0;
    local_dest = local_valid ? local_q[0].t : '0;
    local_is_tail = local_valid ? local_q[0].tl : 1'b0;
    credit_in = ci;
    #1;
    ok = m_cred > 0;
    rwin = ring_valid && !(local_valid && m_burst == LIMIT);
    er = ok && (m_owner == 0 ? rwin : m_owner == 1);
    el = ok && (m_owner == 0 ? local_valid && !rwin : m_owner == 2);
    chk("ring_ready", ring_ready, er);
    chk("local_ready", local_ready, el);
    acc_r = er && ring_valid;
    acc_l = el && local_valid;
    exp_send = acc_r || acc_l;
    if (exp_send) begin
      tl = acc_r ? ring_q[0].tl : local_q[0].tl;
      exp_data = acc_r ? ring_q[0].d : local_q[0].d;
      exp_dest = acc_r ? ring_q[0].t : local_q[0].t;
      exp_tail = tl;
      if (m_owner == 0) begin
        m_burst = acc_r && local_valid ? (m_burst < LIMIT ? m_burst + 1 : LIMIT) : 0;
        m_owner = acc_r ? 1 : 2;
      end
      if (tl) m_owner = 0;
      if (acc_r) void'(ring_q.pop_front()); else void'(local_q.pop_front());
    end
    if (ci && m_cred == DEPTH) m_err = 1;
    m_cred = m_cred - (exp_send ? 1 : 0) + (ci ? 1 : 0);
    if (m_cred > DEPTH) m_cred = DEPTH;
  endtask

  initial begin
    do_reset();
    // local 3-flit packet alone: three back-to-back sends, tail last, one credit left
    push(2, 3);
    repeat (3) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("t1_tail", is_tail_out, 1);
    chk("t1_sends", sends, 3);
    chk("t1_model_cred", m_cred, 1);
    // ring 6-flit packet with no credit returns stalls after four flits
    do_reset();
    push(1, 6);
    repeat (6) cyc(1, 0, 0);
    chk("t2_sends", sends, 4);
    chk("t2_stalled", ring_ready, 0);
    cyc(1, 0, 1);
    chk("t2_k_ready", ring_ready, 0);
    cyc(1, 0, 0);
    chk("t2_k1_send", send_out, 0);
    chk("t2_k1_ready", ring_ready, 1);
    cyc(1, 0, 0);
    chk("t2_k2_send", send_out, 1);
    repeat (10) cyc(1, 0, m_cred < DEPTH);
    // contention with burst limit two
    do_reset();
    repeat (4) push(1, 2);
    repeat (2) push(2, 2);
    repeat (16) cyc(1, 1, m_cred < DEPTH);
    chk("t3_order_RRLRRL", order == "RRLRRL", 1);
    // local waits through ring bubbles inside a locked ring packet
    do_reset();
    push(1, 3);
    push(2, 2);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("t4_bubble1", local_ready, 0);
    cyc(0, 1, 0);
    chk("t4_bubble2", local_ready, 0);
    cyc(1, 1, 1);
    chk("t4_mid", local_ready, 0);
    cyc(1, 1, 1);
    chk("t4_tail", local_ready, 0);
    cyc(1, 1, 1);
    chk("t4_local_granted", local_ready, 1);
    repeat (4) cyc(1, 1, m_cred < DEPTH);
    // simultaneous accept and credit at one credit, then credit overflow
    do_reset();
    push(2, 5);
    repeat (3) cyc(0, 1, 0);
    cyc(0, 1, 1);
    chk("t5_ready_c1", local_ready, 1);
    chk("t5_model_cred1", m_cred, 1);
    cyc(0, 1, 0);
    chk("t5_ready_last", local_ready, 1);
    cyc(0, 1, 0);
    chk("t5_ready_c0", local_ready, 0);
    repeat (4) cyc(0, 0, 1);
    chk("t5_model_cred4", m_cred, 4);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("t5_credit_err", credit_err, 1);
    // reset in the middle of a ring packet
    do_reset();
    push(1, 4);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    do_reset();
    chk("t6_model_cred", m_cred, 4);
    push(2, 1);
    cyc(0, 1, 0);
    chk("t6_local_first", local_ready, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("t6_sent", sends, 1);
    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (ring_q.size() < 6 && $urandom_range(0, 3) == 0) push(1, $urandom_range(1, 4));
      if (local_q.size() < 6 && $urandom_range(0, 3) == 0) push(2, $urandom_range(1, 4));
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, m_cred < DEPTH && $urandom_range(0, 1) == 1);
    end
    repeat (40) cyc(1, 1, m_cred < DEPTH);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
